// File: rtl/mouse_pkg.sv
// Shared types and constants for the mouse cursor tracker.
// Packet layout: {dy, dx, status}, one byte each.
package mouse_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_UPD_X,
      ST_UPD_Y,
      ST_PUBLISH
   } trk_state_t;

   localparam int BIT_L       = 0;
   localparam int BIT_R       = 1;
   localparam int BIT_ALWAYS1 = 3;
   localparam int BIT_XSIGN   = 4;
   localparam int BIT_YSIGN   = 5;
   localparam int BIT_XOVF    = 6;
   localparam int BIT_YOVF    = 7;

   localparam int PKT_STATUS_LSB = 0;
   localparam int PKT_DX_LSB     = 8;
   localparam int PKT_DY_LSB     = 16;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/axis_clamp.sv
// One-axis position step: add a signed 9-bit delta and clamp to [0, MAX].
// An overflowed movement byte is treated as no movement.
module axis_clamp #(
   parameter int MAX = 159
) (
   input  logic [7:0] pos_i,
   input  logic       sign_i,
   input  logic [7:0] mag_i,
   input  logic       ovf_i,
   output logic [7:0] pos_o
);

   localparam logic signed [9:0] MAX_S = 10'(MAX);

   logic        [8:0] delta;
   logic signed [9:0] sum;

   always_comb begin
      delta = ovf_i ? 9'd0 : {sign_i, mag_i};
      sum   = $signed({2'b00, pos_i}) + $signed({delta[8], delta});
      if (sum[9]) begin
         pos_o = 8'd0;
      end else if (sum > MAX_S) begin
         pos_o = MAX_S[7:0];
      end else begin
         pos_o = sum[7:0];
      end
   end

endmodule

// File: rtl/mouse_pos_tracker.sv
// Integrates PS/2 mouse packets into a clamped cursor position and
// publishes it over a valid/ready handshake.
module mouse_pos_tracker
   import mouse_pkg::*;
#(
   parameter int X_MAX  = 159,
   parameter int Y_MAX  = 119,
   parameter int X_INIT = 80,
   parameter int Y_INIT = 60
) (
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic        ps2pkt_vld,
   input  logic [23:0] ps2pkt_data,
   input  logic        recenter,
   output logic        pos_vld,
   input  logic        pos_rdy,
   output logic [7:0]  pos_x,
   output logic [7:0]  pos_y,
   output logic        btn_l,
   output logic        btn_r,
   output logic [7:0]  drop_cnt,
   output logic [7:0]  err_cnt
);

   trk_state_t  state_q, state_d;
   logic [23:0] pkt_q, pkt_d;
   logic [7:0]  x_q, x_d;
   logic [7:0]  y_q, y_d;
   logic        bl_q, bl_d;
   logic        br_q, br_d;
   logic [7:0]  drop_q, drop_d;
   logic [7:0]  err_q, err_d;

   logic [7:0]  status;
   logic [7:0]  dx;
   logic [7:0]  dy;
   logic [7:0]  x_nxt;
   logic [7:0]  y_nxt;
   logic        unused_stat;

   assign status = pkt_q[PKT_STATUS_LSB +: 8];
   assign dx     = pkt_q[PKT_DX_LSB +: 8];
   assign dy     = pkt_q[PKT_DY_LSB +: 8];
   assign unused_stat = status[2];

   axis_clamp #(.MAX(X_MAX)) u_clamp_x (
      .pos_i  (x_q),
      .sign_i (status[BIT_XSIGN]),
      .mag_i  (dx),
      .ovf_i  (status[BIT_XOVF]),
      .pos_o  (x_nxt)
   );

   axis_clamp #(.MAX(Y_MAX)) u_clamp_y (
      .pos_i  (y_q),
      .sign_i (status[BIT_YSIGN]),
      .mag_i  (dy),
      .ovf_i  (status[BIT_YOVF]),
      .pos_o  (y_nxt)
   );

   always_comb begin
      state_d = state_q;
      pkt_d   = pkt_q;
      x_d     = x_q;
      y_d     = y_q;
      bl_d    = bl_q;
      br_d    = br_q;
      drop_d  = drop_q;
      err_d   = err_q;

      // A packet is lost whenever it cannot start a new update.
      if (ps2pkt_vld && (state_q != ST_IDLE || recenter)) begin
         drop_d = sat_inc(drop_q);
      end

      unique case (state_q)
         ST_IDLE: begin
            if (recenter) begin
               x_d     = 8'(X_INIT);
               y_d     = 8'(Y_INIT);
               state_d = ST_PUBLISH;
            end else if (ps2pkt_vld) begin
               pkt_d   = ps2pkt_data;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (!status[BIT_ALWAYS1]) begin
               err_d   = sat_inc(err_q);
               state_d = ST_IDLE;
            end else begin
               bl_d    = status[BIT_L];
               br_d    = status[BIT_R];
               state_d = ST_UPD_X;
            end
         end
         ST_UPD_X: begin
            x_d     = x_nxt;
            state_d = ST_UPD_Y;
         end
         ST_UPD_Y: begin
            y_d     = y_nxt;
            state_d = ST_PUBLISH;
         end
         ST_PUBLISH: begin
            if (pos_rdy) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pkt_q   <= '0;
         x_q     <= 8'(X_INIT);
         y_q     <= 8'(Y_INIT);
         bl_q    <= 1'b0;
         br_q    <= 1'b0;
         drop_q  <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         pkt_q   <= pkt_d;
         x_q     <= x_d;
         y_q     <= y_d;
         bl_q    <= bl_d;
         br_q    <= br_d;
         drop_q  <= drop_d;
         err_q   <= err_d;
      end
   end

   assign pos_vld  = (state_q == ST_PUBLISH);
   assign pos_x    = x_q;
   assign pos_y    = y_q;
   assign btn_l    = bl_q;
   assign btn_r    = br_q;
   assign drop_cnt = drop_q;
   assign err_cnt  = err_q;

endmodule
